// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns the PC and {V,S,C,Z} flags, fetches over req/ack, strobes one execute cycle.
// Optional feature: define PC_MISALIGN_TRAP_EN to halt on a misaligned taken target instead of masking it.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        branch_ctrl,
    input  logic [3:0]  flag_ctrl,
    input  logic [31:0] reg_target,
    input  logic [3:0]  alu_flags,
    input  logic        flag_we,
    output logic [3:0]  flags,
    output logic [31:0] link_pc,
    output logic        trap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [3:0]         flags_q, flags_d;

    logic signed [31:0] off;
    logic [31:0]        seq_pc;
    logic [31:0]        rel_target;
    logic [31:0]        taken_target;
    logic [31:0]        next_pc;
    logic               cond;
    logic               taken;
    logic               misalign;

    // Branch resolution always uses the registered flags, never this cycle's alu_flags.
    always_comb begin
        off          = {{4{instr_q[25]}}, instr_q[25:0], 2'b00};
        seq_pc       = pc_q + 32'd4;
        rel_target   = seq_pc + $unsigned(off);
        cond         = 1'b0;
        taken_target = rel_target;
        case (flag_ctrl)
            4'd4:    cond = 1'b1;
            4'd5:    cond = flags_q[0];
            4'd6:    cond = ~flags_q[0];
            4'd7:    cond = flags_q[1];
            4'd8:    cond = ~flags_q[1];
            4'd9:    cond = flags_q[2];
            4'd10:   cond = ~flags_q[2];
            4'd11:   cond = flags_q[3];
            4'd12:   cond = ~flags_q[3];
            4'd13:   begin cond = 1'b1; taken_target = reg_target; end
            4'd14:   cond = 1'b1;
            4'd15:   begin cond = 1'b1; taken_target = reg_target; end
            default: cond = 1'b0;
        endcase
        taken = branch_ctrl & cond;
`ifdef PC_MISALIGN_TRAP_EN
        misalign = taken & (|taken_target[1:0]);
        next_pc  = taken ? taken_target : seq_pc;
`else
        misalign = 1'b0;
        next_pc  = taken ? (taken_target & ~32'h3) : seq_pc;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (flag_we) flags_d = alu_flags;
                // A faulting target leaves pc pointing at the faulting instruction.
                if (misalign) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_EXEC);
    assign instr       = instr_q;
    assign flags       = flags_q;
    assign link_pc     = pc_q + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
    assign trap        = (state_q == S_HALT);
`else
    assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer, checked against an instruction-level model of PC and flags.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        branch_ctrl;
    logic [3:0]  flag_ctrl;
    logic [31:0] reg_target;
    logic [3:0]  alu_flags;
    logic        flag_we;
    logic [3:0]  flags;
    logic [31:0] link_pc;
    logic        trap;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [3:0]  m_flags;
    bit          m_halt;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .branch_ctrl(branch_ctrl), .flag_ctrl(flag_ctrl), .reg_target(reg_target),
        .alu_flags(alu_flags), .flag_we(flag_we), .flags(flags),
        .link_pc(link_pc), .trap(trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Condition codes 5..12 pair up per flag (Z,C,S,V); odd codes want the flag set.
    function automatic bit cond_met(input logic [3:0] fc, input logic [3:0] f);
        int idx;
        if (fc == 4'd4 || fc >= 4'd13) return 1'b1;
        if (fc >= 4'd5 && fc <= 4'd12) begin
            idx = (int'(fc) - 5) / 2;
            return f[idx] == fc[0];
        end
        return 1'b0;
    endfunction

    task automatic model_exec(input logic [31:0] word, input logic br, input logic [3:0] fc,
                              input logic [31:0] rt, input logic [3:0] af, input logic fwe);
        logic signed [31:0] soff;
        logic [31:0]        tgt;
        soff = $signed(word[25:0]);
        tgt  = (fc == 4'd13 || fc == 4'd15) ? rt : m_pc + 32'd4 + $unsigned(soff * 4);
        if (br && cond_met(fc, m_flags)) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) m_halt = 1'b1;
            else m_pc = tgt;
`else
            m_pc = tgt & ~32'h3;
`endif
        end else begin
            m_pc = m_pc + 32'd4;
        end
        if (fwe) m_flags = af;
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_flags = 4'h0;
        m_halt  = 1'b0;
    endtask

    // Entered one step after an edge with the DUT in FETCH; leaves it in the following FETCH or HALT.
    task automatic do_instr(input logic [31:0] word, input int waits, input logic br, input logic [3:0] fc,
                            input logic [31:0] rt, input logic [3:0] af, input logic fwe);
        logic [31:0] fetch_pc;
        fetch_pc = m_pc;
        chk("fetch_req", {31'h0, imem_req}, 32'h1);
        chk("fetch_addr", imem_addr, fetch_pc);
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, fetch_pc);
            chk("wait_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack    = $urandom_range(0, 1);
        imem_rdata  = $urandom;
        branch_ctrl = br;
        flag_ctrl   = fc;
        reg_target  = rt;
        alu_flags   = af;
        flag_we     = fwe;
        #1;
        chk("exec_valid", {31'h0, instr_valid}, 32'h1);
        chk("exec_req", {31'h0, imem_req}, 32'h0);
        chk("exec_instr", instr, word);
        chk("exec_link", link_pc, fetch_pc + 32'd4);
        model_exec(word, br, fc, rt, af, fwe);
        tick();
        imem_ack    = 1'b0;
        branch_ctrl = 1'b0;
        flag_we     = 1'b0;
        chk("post_valid", {31'h0, instr_valid}, 32'h0);
        chk("post_flags", {28'h0, flags}, {28'h0, m_flags});
        chk("post_addr", imem_addr, m_pc);
        chk("post_trap", {31'h0, trap}, {31'h0, m_halt});
        chk("post_req", {31'h0, imem_req}, {31'h0, !m_halt});
        if (m_halt) begin
            imem_ack = 1'b1;
            tick();
            tick();
            chk("halt_trap", {31'h0, trap}, 32'h1);
            chk("halt_req", {31'h0, imem_req}, 32'h0);
            chk("halt_addr", imem_addr, m_pc);
            imem_ack = 1'b0;
        end
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_trap", {31'h0, trap}, 32'h0);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        chk("rst_first_req", {31'h0, imem_req}, 32'h1);
        chk("rst_first_addr", imem_addr, RST_PC);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        branch_ctrl = 1'b0; flag_ctrl = 4'h0; reg_target = 32'h0; alu_flags = 4'h0; flag_we = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        chk("reset_valid", {31'h0, instr_valid}, 32'h0);
        chk("reset_trap", {31'h0, trap}, 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_flags", {28'h0, flags}, 32'h0);
        chk("reset_addr", imem_addr, RST_PC);
        rst = 1'b0;
        #1;
        chk("release_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("first_req", {31'h0, imem_req}, 32'h1);

        // Back-to-back fetches, then a 3-cycle ack delay that also sets Z
        do_instr(32'h1111_0000, 0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0);
        do_instr(32'h2222_0000, 3, 1'b0, 4'd0, 32'h0, 4'b0001, 1'b1);
        chk("pc8", m_pc, 32'h8);
        // bz -2 at pc=8 with Z=1 and then Z=0
        w = 32'hFC00_0000 | 32'h03FF_FFFE;
        do_instr(w, 0, 1'b1, 4'd5, 32'h0, 4'h0, 1'b0);
        chk("bz_taken_addr", imem_addr, 32'h4);
        do_instr(32'h0, 1, 1'b0, 4'd0, 32'h0, 4'b0000, 1'b1);
        do_instr(w, 0, 1'b1, 4'd5, 32'h0, 4'h0, 1'b0);
        chk("bz_not_taken_addr", imem_addr, 32'hC);
        // Same-cycle alu_flags must not steer the branch
        do_instr(w, 0, 1'b1, 4'd5, 32'h0, 4'b0001, 1'b1);
        chk("bz_sameflag_addr", imem_addr, 32'h10);
        chk("bz_sameflag_flags", {28'h0, flags}, 32'h1);
        // Register jumps, aligned then misaligned
        do_instr(32'h0, 0, 1'b1, 4'd13, 32'h100, 4'h0, 1'b0);
        chk("jr_addr", imem_addr, 32'h100);
        do_instr(32'h0, 0, 1'b1, 4'd13, 32'h102, 4'h0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("jr_mis_trap", {31'h0, trap}, 32'h1);
        chk("jr_mis_req", {31'h0, imem_req}, 32'h0);
        reset_seq();
`else
        chk("jr_mis_addr", imem_addr, 32'h100);
`endif
        // Reset during a FETCH wait at pc=0x40 with an ack pending
        do_instr(32'h0, 0, 1'b1, 4'd15, 32'h40, 4'b1010, 1'b1);
        chk("pc40_addr", imem_addr, 32'h40);
        imem_ack = 1'b0;
        tick();
        chk("pc40_wait_req", {31'h0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_req", {31'h0, imem_req}, 32'h0);
        chk("abort_addr", imem_addr, RST_PC);
        chk("abort_flags", {28'h0, flags}, 32'h0);
        tick();
        chk("abort_instr", instr, 32'h0);
        chk("abort_hold_req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b0;
        rst = 1'b0;
        model_reset();
        tick();
        chk("abort_refetch_req", {31'h0, imem_req}, 32'h1);
        chk("abort_refetch_addr", imem_addr, RST_PC);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt = rt & ~32'h3;
            do_instr($urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     rt, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if (m_halt) reset_seq();
        end
        // Wrap from the top of the address space
        do_instr(32'h0, 0, 1'b1, 4'd15, 32'hFFFF_FFFC, 4'h0, 1'b0);
        do_instr(32'h0, 0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
